unified_memory_arbiter: RTL and testbench
=========================================

Name: unified_memory_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the MIPS32 pipeline.
- Sequences each access with a request/ready handshake and generates the stall signals that hold the IF/ID and EX/MEM pipeline registers.
- Gives data accesses priority, bounded by a fairness counter, and aborts accesses that exceed a watchdog timeout.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MAX_DM_STREAK, 4, consecutive data grants allowed while an instruction fetch is waiting (range 1..15).
- TIMEOUT, 16, cycles to wait for mem_ready before aborting (range 2..255).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched word, valid while if_done=1.
- if_done  out  1  one-cycle completion pulse.
- dm_req  in  1  data request; held high until dm_done.
- dm_write  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data, valid while dm_done=1.
- dm_done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access in this cycle.
- timeout_err  out  1  one-cycle pulse when an access is aborted; coincides with the done pulse.
- stall_if  out  1  combinational: if_req & ~if_done.
- stall_mem  out  1  combinational: dm_req & ~dm_done.

Behaviour:
- Reset state (synchronous, active-high):
  - FSM = IDLE.
  - All registered outputs = 0: mem_en, mem_we, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, timeout_err.
  - streak counter and timeout counter = 0.
  - Reset asserted mid-access abandons the access with no done pulse.
- FSM states: IDLE, IF_ACC, DM_ACC, RESP.
- IDLE arbitration, evaluated at each clock edge:
  - Only if_req high: grant IF.
  - Only dm_req high: grant DM.
  - Both high: grant DM, unless streak == MAX_DM_STREAK, in which case grant IF.
  - Neither high: stay in IDLE.
- On a grant, at the same edge:
  - Register address, write enable and write data; mem_we = dm_write for DM, 0 for IF.
  - Set mem_en = 1 and clear the timeout counter.
  - Move to IF_ACC or DM_ACC.
- Streak counter:
  - DM grant with if_req high: streak +1, saturating at MAX_DM_STREAK.
  - DM grant with if_req low: streak = 0.
  - IF grant: streak = 0.
- IF_ACC / DM_ACC:
  - mem_en and the registered buses are held stable; the timeout counter increments each cycle.
  - mem_ready=1 at an edge:
    - capture mem_rdata into the granted requester's rdata register;
    - pulse that requester's done for the next cycle;
    - mem_en = 0, move to RESP.
  - A DM store completion loads dm_rdata = 0.
  - Timeout counter reaches TIMEOUT-1 with no mem_ready:
    - same transition as a completion, but rdata = 0 and timeout_err pulses alongside done;
    - mem_ready wins if both occur at the same edge.
- RESP:
  - Lasts exactly one cycle; the done pulse is visible here.
  - No grant is made, so a request still high from the completed requester is not re-granted.
  - Return to IDLE.
- Latency: request high in IDLE at edge t → mem_en high from t+1.
  - If mem_ready first seen at edge t+1+k, done is high during the cycle after t+1+k and the FSM is back in IDLE one cycle later.
  - Minimum round trip is 3 cycles per access.
- if_rdata and dm_rdata hold their values between accesses.
- done, timeout_err and mem_en are never high for both requesters simultaneously.
- A request that drops before its grant is ignored. Dropping a request after its grant is illegal; the access completes regardless.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ready one cycle after mem_en with mem_rdata=0x2008_0005 → mem_en one cycle, mem_we=0, if_done pulse with if_rdata=0x2008_0005, stall_if low after the pulse.
- Store: dm_req=1, dm_write=1, dm_addr=0x1000_0004, dm_wdata=0xDEAD_BEEF, mem_ready after 2 wait cycles → mem_we=1 for 3 cycles with stable buses, dm_done pulse, dm_rdata=0.
- Contention and fairness (MAX_DM_STREAK=4): if_req and dm_req held high, each access ready immediately → grant order DM,DM,DM,DM,IF,DM…; stall_if high throughout the DM grants.
- Timeout (TIMEOUT=16): dm_req load, mem_ready held low → abort after 16 cycles of mem_en, dm_done and timeout_err pulse together, dm_rdata=0, FSM returns to IDLE.
- Reset mid-access: reset asserted while in DM_ACC, then mem_ready=1 → no done pulse, all outputs 0 the cycle after reset, a new if_req is granted normally after reset deasserts.
- Held request: if_req kept high through its if_done pulse → RESP cycle shows no grant, then a second fetch starts from IDLE.

Source files
------------

// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with data priority bounded by a fairness streak and a watchdog abort.
module unified_memory_arbiter #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_DM_STREAK = 4,
   parameter int TIMEOUT       = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_done,
   input  logic                  dm_req,
   input  logic                  dm_write,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_done,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  timeout_err,
   output logic                  stall_if,
   output logic                  stall_mem
);

   typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t                r_state;
   state_t                w_nextState;
   logic                  w_grantIf;
   logic                  w_grantDm;
   logic                  w_finish;
   logic                  w_accBusy;

   logic [3:0]            r_streak;
   logic [7:0]            r_timer;
   logic                  r_memEn;
   logic                  r_memWe;
   logic [ADDR_WIDTH-1:0] r_memAddr;
   logic [DATA_WIDTH-1:0] r_memWdata;
   logic [DATA_WIDTH-1:0] r_ifRdata;
   logic [DATA_WIDTH-1:0] r_dmRdata;
   logic                  r_ifDone;
   logic                  r_dmDone;
   logic                  r_timeoutErr;

   assign w_accBusy = (r_state == IF_ACC) || (r_state == DM_ACC);

   // Data wins contention unless it has already taken MAX_DM_STREAK grants while a fetch waited.
   always_comb begin
      w_nextState = r_state;
      w_grantIf   = 1'b0;
      w_grantDm   = 1'b0;
      w_finish    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (dm_req && (!if_req || (r_streak != STREAK_MAX))) begin
               w_grantDm   = 1'b1;
               w_nextState = DM_ACC;
            end else if (if_req) begin
               w_grantIf   = 1'b1;
               w_nextState = IF_ACC;
            end
         end
         IF_ACC, DM_ACC: begin
            if (mem_ready || (r_timer == TIMER_LAST)) begin
               w_finish    = 1'b1;
               w_nextState = RESP;
            end
         end
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_streak     <= '0;
         r_timer      <= '0;
         r_memEn      <= 1'b0;
         r_memWe      <= 1'b0;
         r_memAddr    <= '0;
         r_memWdata   <= '0;
         r_ifRdata    <= '0;
         r_dmRdata    <= '0;
         r_ifDone     <= 1'b0;
         r_dmDone     <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_ifDone     <= 1'b0;
         r_dmDone     <= 1'b0;
         r_timeoutErr <= 1'b0;
         if (w_grantDm || w_grantIf) begin
            r_memEn    <= 1'b1;
            r_memWe    <= w_grantDm & dm_write;
            r_memAddr  <= w_grantDm ? dm_addr : if_addr;
            r_memWdata <= w_grantDm ? dm_wdata : '0;
            r_timer    <= '0;
            if (w_grantDm && if_req) begin
               r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 4'd1;
            end else begin
               r_streak <= '0;
            end
         end else if (w_finish) begin
            // A timed-out access returns zero data; mem_ready wins a tie with the watchdog.
            r_memEn      <= 1'b0;
            r_timeoutErr <= ~mem_ready;
            if (r_state == IF_ACC) begin
               r_ifDone  <= 1'b1;
               r_ifRdata <= mem_ready ? mem_rdata : '0;
            end else begin
               r_dmDone  <= 1'b1;
               r_dmRdata <= (mem_ready && !r_memWe) ? mem_rdata : '0;
            end
         end else if (w_accBusy) begin
            r_timer <= r_timer + 8'd1;
         end
      end
   end

   assign if_rdata    = r_ifRdata;
   assign if_done     = r_ifDone;
   assign dm_rdata    = r_dmRdata;
   assign dm_done     = r_dmDone;
   assign mem_en      = r_memEn;
   assign mem_we      = r_memWe;
   assign mem_addr    = r_memAddr;
   assign mem_wdata   = r_memWdata;
   assign timeout_err = r_timeoutErr;
   assign stall_if    = if_req & ~r_ifDone;
   assign stall_mem   = dm_req & ~r_dmDone;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: directed scenarios then randomized contention,
// scored against a transaction-level memory and arbitration model.
module tb_unified_memory_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;
   localparam int TMO  = 16;

   typedef struct {
      bit          isDm;
      logic [31:0] rdata;
      bit          err;
      int          doneCycle;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          dm_req = 1'b0;
   logic          dm_write = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_done;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          timeout_err;
   logic          stall_if;
   logic          stall_mem;

   int testsRun      = 0;
   int testsFailed   = 0;
   int cycle         = 0;
   int forceLat      = -1;
   int remLat        = -1;
   int refStreak     = 0;
   int lastDoneCycle = -10;
   int lastRiseCycle = -10;
   exp_t        expQ[$];
   bit          grantLog[$];
   logic [31:0] refMem [logic [31:0]];

   unified_memory_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)
   ) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .timeout_err(timeout_err), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycle++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checkOutput(name, {31'd0, actual}, {31'd0, expected});
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (refMem.exists(a)) return refMem[a];
      return a ^ 32'h5A5A_F00D;
   endfunction

   // Memory responder: ready arrives remLat cycles into an access; data is noise otherwise.
   initial begin
      forever begin
         @(negedge clock);
         if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_en && remLat == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem_we ? $urandom : memRead(mem_addr);
            remLat    = -1;
            continue;
         end else if (mem_en && remLat > 0) begin
            remLat--;
         end
         mem_rdata = $urandom;
      end
   end

   // Access monitor: on each new access predict the winner and push the expected response.
   initial begin
      bit          prevEn = 1'b0;
      logic [31:0] startAddr = '0;
      logic        startWe = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (!reset && mem_en && !prevEn) begin
            bit   expDm;
            bit   timedOut;
            int   lat;
            exp_t e;
            expDm = (dm_req && if_req) ? (refStreak != MAXS) : dm_req;
            checkOutput("grant_addr", mem_addr, expDm ? dm_addr : if_addr);
            checkBit("grant_we", mem_we, expDm ? dm_write : 1'b0);
            if (expDm && dm_write) checkOutput("grant_wdata", mem_wdata, dm_wdata);
            checkBit("resp_gap", (cycle - lastDoneCycle) >= 2, 1'b1);
            if (expDm) refStreak = if_req ? ((refStreak < MAXS) ? refStreak + 1 : MAXS) : 0;
            else       refStreak = 0;
            grantLog.push_back(mem_addr[28]);
            lastRiseCycle = cycle;
            if (forceLat >= 0) lat = forceLat;
            else if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(TMO - 2, TMO + 2));
            else lat = int'($urandom_range(0, 3));
            timedOut    = (lat + 1) > TMO;
            e.isDm      = expDm;
            e.err       = timedOut;
            e.doneCycle = cycle + (timedOut ? TMO : lat + 1);
            if (timedOut) begin
               e.rdata = '0;
            end else if (expDm && dm_write) begin
               e.rdata = '0;
               refMem[dm_addr] = dm_wdata;
            end else begin
               e.rdata = memRead(expDm ? dm_addr : if_addr);
            end
            expQ.push_back(e);
            remLat    = lat;
            startAddr = mem_addr;
            startWe   = mem_we;
         end else if (!reset && mem_en) begin
            checkOutput("bus_addr_stable", mem_addr, startAddr);
            checkBit("bus_we_stable", mem_we, startWe);
         end
         prevEn = mem_en;
      end
   end

   // Response monitor: pops the scoreboard whenever a done pulse is presented.
   initial begin
      forever begin
         @(posedge clock); #1;
         if (!reset) begin
            checkBit("stall_if", stall_if, if_req & ~if_done);
            checkBit("stall_mem", stall_mem, dm_req & ~dm_done);
            if (if_done || dm_done) begin
               exp_t e;
               checkBit("done_exclusive", if_done & dm_done, 1'b0);
               checkBit("mem_en_in_resp", mem_en, 1'b0);
               if (expQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL unexpected_done: if_done=%0b dm_done=%0b, required no done", if_done, dm_done);
               end else begin
                  e = expQ.pop_front();
                  checkBit("done_requester", dm_done, e.isDm);
                  checkOutput("done_rdata", e.isDm ? dm_rdata : if_rdata, e.rdata);
                  checkBit("timeout_err", timeout_err, e.err);
                  checkOutput("done_cycle", cycle, e.doneCycle);
               end
               lastDoneCycle = cycle;
            end else begin
               checkBit("timeout_err_idle", timeout_err, 1'b0);
            end
         end
      end
   end

   task automatic waitDone(input bit isDm, input int bound, output int doneAt);
      doneAt = -1;
      for (int w = 0; w < bound; w++) begin
         @(posedge clock); #1;
         if (isDm ? dm_done : if_done) begin
            doneAt = cycle;
            return;
         end
      end
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s_done_wait: no done pulse within %0d cycles, required one", isDm ? "dm" : "if", bound);
   endtask

   task automatic waitIdle();
      int w = 0;
      while ((mem_en || expQ.size() != 0) && w < 200) begin
         @(posedge clock); #1;
         w++;
      end
      checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
   endtask

   task automatic applyStimulus(input bit isDm, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, output int doneAt);
      forceLat = lat;
      @(negedge clock);
      if (isDm) begin
         dm_req = 1'b1; dm_write = wr; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      waitDone(isDm, 60, doneAt);
      @(negedge clock);
      if (isDm) dm_req = 1'b0;
      else      if_req = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkBit({tag, "_mem_en"}, mem_en, 1'b0);
      checkBit({tag, "_mem_we"}, mem_we, 1'b0);
      checkOutput({tag, "_mem_addr"}, mem_addr, '0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, '0);
      checkBit({tag, "_if_done"}, if_done, 1'b0);
      checkBit({tag, "_dm_done"}, dm_done, 1'b0);
      checkOutput({tag, "_if_rdata"}, if_rdata, '0);
      checkOutput({tag, "_dm_rdata"}, dm_rdata, '0);
      checkBit({tag, "_timeout_err"}, timeout_err, 1'b0);
   endtask

   task automatic ifRequester(input int n);
      int d;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if_req  = 1'b1;
         if_addr = 32'($urandom_range(0, 63)) << 2;
         waitDone(1'b0, 300, d);
         if ($urandom_range(0, 3) != 0) begin
            @(negedge clock);
            if_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
         end
      end
      @(negedge clock);
      if_req = 1'b0;
   endtask

   task automatic dmRequester(input int n);
      int d;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         dm_req   = 1'b1;
         dm_write = 1'($urandom_range(0, 1));
         dm_addr  = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
         dm_wdata = $urandom;
         waitDone(1'b1, 300, d);
         if ($urandom_range(0, 3) != 0) begin
            @(negedge clock);
            dm_req = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
         end
      end
      @(negedge clock);
      dm_req = 1'b0;
   endtask

   initial begin
      int d;
      int d1;
      int w;
      bit pattern [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      repeat (3) @(posedge clock);
      #1;
      checkResetOutputs("reset");
      @(negedge clock);
      reset = 1'b0;

      // Single fetch with immediate ready.
      refMem[32'h0000_0040] = 32'h2008_0005;
      applyStimulus(1'b0, 1'b0, 32'h0000_0040, '0, 0, d);
      checkOutput("fetch_rdata", if_rdata, 32'h2008_0005);
      checkOutput("fetch_en_cycles", 32'(d - lastRiseCycle), 32'd1);

      // Store with two wait cycles: three cycles of mem_en, zero dm_rdata.
      applyStimulus(1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2, d);
      checkOutput("store_en_cycles", 32'(d - lastRiseCycle), 32'd3);
      checkOutput("store_dm_rdata", dm_rdata, '0);
      checkOutput("fetch_rdata_held", if_rdata, 32'h2008_0005);

      // Load back the stored word.
      applyStimulus(1'b1, 1'b0, 32'h1000_0004, '0, 1, d);
      checkOutput("load_after_store", dm_rdata, 32'hDEAD_BEEF);

      // Watchdog abort, then ready on the watchdog's last cycle.
      applyStimulus(1'b1, 1'b0, 32'h1000_0020, '0, 100, d);
      checkOutput("timeout_en_cycles", 32'(d - lastRiseCycle), 32'(TMO));
      checkOutput("timeout_dm_rdata", dm_rdata, '0);
      applyStimulus(1'b1, 1'b0, 32'h1000_0024, '0, TMO - 1, d);
      checkOutput("late_ready_en_cycles", 32'(d - lastRiseCycle), 32'(TMO));
      checkOutput("late_ready_rdata", dm_rdata, memRead(32'h1000_0024));

      // Contention: both requests held, data streak bounded.
      grantLog.delete();
      forceLat = 0;
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h0000_0080;
      dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h1000_0040;
      w = 0;
      while (grantLog.size() < 6 && w < 100) begin
         @(posedge clock); #1;
         w++;
      end
      @(negedge clock);
      if_req = 1'b0;
      dm_req = 1'b0;
      checkBit("fair_grant_count", grantLog.size() >= 6, 1'b1);
      for (int i = 0; i < 6 && i < grantLog.size(); i++)
         checkBit($sformatf("fair_grant%0d", i), grantLog[i], pattern[i]);
      waitIdle();

      // Held fetch request: RESP then IDLE, second grant two cycles after done.
      forceLat = 0;
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h0000_0100;
      waitDone(1'b0, 60, d1);
      w = 0;
      while (lastRiseCycle <= d1 && w < 10) begin
         @(posedge clock); #1;
         w++;
      end
      checkOutput("held_regrant_cycle", 32'(lastRiseCycle), 32'(d1 + 2));
      waitDone(1'b0, 60, d);
      @(negedge clock);
      if_req = 1'b0;

      // Reset during a data access coinciding with mem_ready.
      forceLat = 0;
      @(negedge clock);
      dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h1000_0030;
      w = 0;
      while (!mem_en && w < 20) begin
         @(posedge clock); #1;
         w++;
      end
      @(negedge clock);
      reset  = 1'b1;
      dm_req = 1'b0;
      @(posedge clock); #1;
      checkResetOutputs("midreset");
      expQ.delete();
      refStreak = 0;
      remLat    = -1;
      @(posedge clock); #1;
      checkBit("midreset_no_done", dm_done, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0000_0044, '0, 1, d);
      checkOutput("post_reset_fetch", if_rdata, memRead(32'h0000_0044));

      // Randomized contention.
      forceLat = -1;
      fork
         ifRequester(80);
         dmRequester(80);
      join
      waitIdle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL global_watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
